// File: rtl/alu20.sv
// -----------------------------------------------------------------------------
// alu20 - 20-bit registered ALU for the 20-bit-instruction CPU datapath.
//
// Eight arithmetic/logic operations are selected by a 3-bit opcode. The
// datapath is purely combinational into a single register stage. Result and
// status flags appear one clock after a valid request. The equality flag feeds
// the branch-if-equal decision in the control unit.
//
// Ports
//   clk         in   1      system clock, rising edge
//   rst_n       in   1      asynchronous active-low reset
//   in_valid    in   1      operands/opcode valid this cycle
//   in1         in   WIDTH  operand A
//   in2         in   WIDTH  operand B
//   op_code     in   3      operation select
//   out_valid   out  1      registered: result/flags valid
//   result      out  WIDTH  registered result
//   equal_flag  out  1      registered: in1 == in2 (independent of opcode)
//   zero_flag   out  1      registered: result == 0
//   carry_flag  out  1      registered: carry (ADD) / not-borrow (SUB), else 0
//   ovf_flag    out  1      registered: signed overflow (ADD/SUB), else 0
//
// Opcodes
//   000 ADD  001 SUB  010 AND  011 OR  100 XOR  101 NAND  110 NOR  111 SLT
// -----------------------------------------------------------------------------
module alu20 #(
  parameter int WIDTH = 20
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in1,
  input  logic [WIDTH-1:0] in2,
  input  logic [2:0]       op_code,
  output logic             out_valid,
  output logic [WIDTH-1:0] result,
  output logic             equal_flag,
  output logic             zero_flag,
  output logic             carry_flag,
  output logic             ovf_flag
);

  localparam logic [2:0] OP_ADD  = 3'b000;
  localparam logic [2:0] OP_SUB  = 3'b001;
  localparam logic [2:0] OP_AND  = 3'b010;
  localparam logic [2:0] OP_OR   = 3'b011;
  localparam logic [2:0] OP_XOR  = 3'b100;
  localparam logic [2:0] OP_NAND = 3'b101;
  localparam logic [2:0] OP_NOR  = 3'b110;
  localparam logic [2:0] OP_SLT  = 3'b111;

  // Adder with carry-in. Returns {carry_out, signed_overflow, sum}.
  // Overflow is the classic rule on the effective operands: both operand
  // signs equal and the sum sign differs. Because SUB is fed the inverted
  // B operand, the same rule gives "operand signs differ and result sign
  // differs from A" for subtraction.
  function automatic logic [WIDTH+1:0] add_flags(
    input logic [WIDTH-1:0] a,
    input logic [WIDTH-1:0] b,
    input logic             cin
  );
    logic [WIDTH:0] sum;
    logic           ovf;
    sum = {1'b0, a} + {1'b0, b} + {{WIDTH{1'b0}}, cin};
    ovf = (a[WIDTH-1] == b[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);
    return {sum[WIDTH], ovf, sum[WIDTH-1:0]};
  endfunction

  // Signed less-than on two's-complement operands.
  function automatic logic signed_lt(
    input logic [WIDTH-1:0] a,
    input logic [WIDTH-1:0] b
  );
    return $signed(a) < $signed(b);
  endfunction

  logic             sub_sel_s;
  logic [WIDTH-1:0] b_eff_s;
  logic [WIDTH+1:0] arith_s;
  logic             slt_s;

  logic [WIDTH-1:0] result_d;
  logic             carry_d;
  logic             ovf_d;
  logic             zero_d;
  logic             equal_d;

  logic             out_valid_q;
  logic [WIDTH-1:0] result_q;
  logic             equal_q;
  logic             zero_q;
  logic             carry_q;
  logic             ovf_q;

  // Shared adder: SUB reuses it as in1 + ~in2 + 1 so carry means no borrow.
  always_comb begin
    sub_sel_s = (op_code == OP_SUB);
    if (sub_sel_s) begin
      b_eff_s = ~in2;
    end else begin
      b_eff_s = in2;
    end
    arith_s = add_flags(in1, b_eff_s, sub_sel_s);
    slt_s   = signed_lt(in1, in2);
  end

  // Operation select and next-state flag computation.
  always_comb begin
    result_d = {WIDTH{1'b0}};
    carry_d  = 1'b0;
    ovf_d    = 1'b0;
    case (op_code)
      OP_ADD, OP_SUB: begin
        result_d = arith_s[WIDTH-1:0];
        carry_d  = arith_s[WIDTH+1];
        ovf_d    = arith_s[WIDTH];
      end
      OP_AND:  result_d = in1 & in2;
      OP_OR:   result_d = in1 | in2;
      OP_XOR:  result_d = in1 ^ in2;
      OP_NAND: result_d = ~(in1 & in2);
      OP_NOR:  result_d = ~(in1 | in2);
      OP_SLT:  result_d = {{(WIDTH-1){1'b0}}, slt_s};
      default: begin
        result_d = {WIDTH{1'b0}};
        carry_d  = 1'b0;
        ovf_d    = 1'b0;
      end
    endcase
    // Zero flag is taken from the next result so it lines up with result.
    zero_d  = (result_d == {WIDTH{1'b0}});
    equal_d = (in1 == in2);
  end

  // Output register stage; results and flags hold while no request arrives.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      result_q    <= {WIDTH{1'b0}};
      equal_q     <= 1'b0;
      zero_q      <= 1'b0;
      carry_q     <= 1'b0;
      ovf_q       <= 1'b0;
    end else begin
      out_valid_q <= in_valid;
      if (in_valid) begin
        result_q <= result_d;
        equal_q  <= equal_d;
        zero_q   <= zero_d;
        carry_q  <= carry_d;
        ovf_q    <= ovf_d;
      end else begin
        result_q <= result_q;
        equal_q  <= equal_q;
        zero_q   <= zero_q;
        carry_q  <= carry_q;
        ovf_q    <= ovf_q;
      end
    end
  end

  assign out_valid  = out_valid_q;
  assign result     = result_q;
  assign equal_flag = equal_q;
  assign zero_flag  = zero_q;
  assign carry_flag = carry_q;
  assign ovf_flag   = ovf_q;

endmodule

// File: tb/tb_alu20.sv
// -----------------------------------------------------------------------------
// tb_alu20 - directed-vector bench for alu20 with a queue-based scoreboard.
// The stimulus process drives a request on the falling edge and pushes the
// hand-computed response; the monitor pops and compares after each rising
// edge whenever a response is due.
// -----------------------------------------------------------------------------
module tb_alu20;

  typedef struct packed {
    logic [7:0]  id;
    logic [19:0] res;
    logic        eq;
    logic        z;
    logic        c;
    logic        o;
  } exp_t;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic [19:0] in1;
  logic [19:0] in2;
  logic [2:0]  op_code;
  logic        out_valid;
  logic [19:0] result;
  logic        equal_flag;
  logic        zero_flag;
  logic        carry_flag;
  logic        ovf_flag;

  exp_t sb_q[$];
  exp_t last_exp;
  int   n_cmp;
  int   n_bad;
  int   next_id;

  alu20 #(.WIDTH(20)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in1        (in1),
    .in2        (in2),
    .op_code    (op_code),
    .out_valid  (out_valid),
    .result     (result),
    .equal_flag (equal_flag),
    .zero_flag  (zero_flag),
    .carry_flag (carry_flag),
    .ovf_flag   (ovf_flag)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input int id, input logic [31:0] act,
                       input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s (vec %0d): got 0x%0h expected 0x%0h", name, id, act, exp);
    end
  endtask

  // Drive one valid request on the falling edge and queue its expected response.
  task automatic issue(input logic [19:0] a, input logic [19:0] b, input logic [2:0] op,
                       input logic [19:0] res, input logic eq, input logic z,
                       input logic c, input logic o);
    exp_t e;
    @(negedge clk);
    in_valid = 1'b1;
    in1      = a;
    in2      = b;
    op_code  = op;
    e.id  = next_id[7:0];
    e.res = res;
    e.eq  = eq;
    e.z   = z;
    e.c   = c;
    e.o   = o;
    sb_q.push_back(e);
    next_id++;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      in_valid = 1'b0;
      in1      = 20'hABCDE;
      in2      = 20'h12345;
      op_code  = 3'b000;
    end
  endtask

  // Monitor: after each rising edge, pop a due response or check held outputs.
  initial begin
    exp_t e;
    last_exp = '0;
    forever begin
      @(posedge clk);
      #1;
      if (!rst_n) begin
        last_exp = '0;
      end else if (sb_q.size() > 0) begin
        e = sb_q.pop_front();
        check("out_valid", int'(e.id), {31'd0, out_valid}, 32'd1);
        check("result", int'(e.id), {12'd0, result}, {12'd0, e.res});
        check("flags eq/z/c/o", int'(e.id),
              {28'd0, equal_flag, zero_flag, carry_flag, ovf_flag},
              {28'd0, e.eq, e.z, e.c, e.o});
        last_exp = e;
      end else begin
        check("idle out_valid", -1, {31'd0, out_valid}, 32'd0);
        check("hold result+flags", int'(last_exp.id),
              {8'd0, result, equal_flag, zero_flag, carry_flag, ovf_flag},
              {8'd0, last_exp.res, last_exp.eq, last_exp.z, last_exp.c, last_exp.o});
      end
    end
  end

  // Watchdog so the run always ends.
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit expired");
    $fatal(1, "timeout");
  end

  // Stimulus.
  initial begin
    n_cmp    = 0;
    n_bad    = 0;
    next_id  = 0;
    rst_n    = 1'b0;
    in_valid = 1'b0;
    in1      = 20'h00000;
    in2      = 20'h00000;
    op_code  = 3'b000;
    #1;
    check("reset outputs", -1,
          {7'd0, out_valid, result, equal_flag, zero_flag, carry_flag, ovf_flag}, 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    idle(1);

    // Basic add of equal operands.
    issue(20'h000FF, 20'h000FF, 3'b000, 20'h001FE, 1'b1, 1'b0, 1'b0, 1'b0);
    // All eight ops on 0xFF / 0x55, back to back.
    issue(20'h000FF, 20'h00055, 3'b000, 20'h00154, 1'b0, 1'b0, 1'b0, 1'b0);
    issue(20'h000FF, 20'h00055, 3'b001, 20'h000AA, 1'b0, 1'b0, 1'b1, 1'b0);
    issue(20'h000FF, 20'h00055, 3'b010, 20'h00055, 1'b0, 1'b0, 1'b0, 1'b0);
    issue(20'h000FF, 20'h00055, 3'b011, 20'h000FF, 1'b0, 1'b0, 1'b0, 1'b0);
    issue(20'h000FF, 20'h00055, 3'b100, 20'h000AA, 1'b0, 1'b0, 1'b0, 1'b0);
    issue(20'h000FF, 20'h00055, 3'b101, 20'hFFFAA, 1'b0, 1'b0, 1'b0, 1'b0);
    issue(20'h000FF, 20'h00055, 3'b110, 20'hFFF00, 1'b0, 1'b0, 1'b0, 1'b0);
    issue(20'h000FF, 20'h00055, 3'b111, 20'h00000, 1'b0, 1'b1, 1'b0, 1'b0);
    // Overflow and carry boundaries.
    issue(20'h7FFFF, 20'h00001, 3'b000, 20'h80000, 1'b0, 1'b0, 1'b0, 1'b1);
    issue(20'hFFFFF, 20'h00001, 3'b000, 20'h00000, 1'b0, 1'b1, 1'b1, 1'b0);
    // Borrow, signed SUB overflow, equal SUB.
    issue(20'h00001, 20'h00002, 3'b001, 20'hFFFFF, 1'b0, 1'b0, 1'b0, 1'b0);
    issue(20'h80000, 20'h00001, 3'b001, 20'h7FFFF, 1'b0, 1'b0, 1'b1, 1'b1);
    issue(20'h12345, 20'h12345, 3'b001, 20'h00000, 1'b1, 1'b1, 1'b1, 1'b0);
    // Signed SLT cases.
    issue(20'h80000, 20'h00001, 3'b111, 20'h00001, 1'b0, 1'b0, 1'b0, 1'b0);
    issue(20'h00001, 20'h80000, 3'b111, 20'h00000, 1'b0, 1'b1, 1'b0, 1'b0);
    issue(20'hFFFFF, 20'h00000, 3'b111, 20'h00001, 1'b0, 1'b0, 1'b0, 1'b0);
    issue(20'h55555, 20'h55555, 3'b111, 20'h00000, 1'b1, 1'b1, 1'b0, 1'b0);
    // Logic ops producing zero / all ones.
    issue(20'hF0F0F, 20'h0F0F0, 3'b010, 20'h00000, 1'b0, 1'b1, 1'b0, 1'b0);
    issue(20'hF0F0F, 20'h0F0F0, 3'b110, 20'h00000, 1'b0, 1'b1, 1'b0, 1'b0);
    issue(20'h00000, 20'h00000, 3'b101, 20'hFFFFF, 1'b1, 1'b0, 1'b0, 1'b0);

    // Hold: a valid op followed by three idle cycles.
    issue(20'h0ABCD, 20'h01111, 3'b100, 20'h0BADC, 1'b0, 1'b0, 1'b0, 1'b0);
    idle(3);

    // Async reset while out_valid is high.
    issue(20'h7FFFF, 20'h00001, 3'b000, 20'h80000, 1'b0, 1'b0, 1'b0, 1'b1);
    @(posedge clk);
    #3;
    check("pre-reset out_valid", -1, {31'd0, out_valid}, 32'd1);
    rst_n = 1'b0;
    #1;
    check("async reset outputs", -1,
          {7'd0, out_valid, result, equal_flag, zero_flag, carry_flag, ovf_flag}, 32'd0);
    idle(2);
    rst_n = 1'b1;
    // First valid after release.
    issue(20'h00010, 20'h00020, 3'b011, 20'h00030, 1'b0, 1'b0, 1'b0, 1'b0);
    idle(1);

    // Drain: bounded wait for the scoreboard to empty.
    for (int i = 0; i < 10 && sb_q.size() > 0; i++) @(negedge clk);
    check("scoreboard drained", -1, sb_q.size(), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
